// File: rtl/swap_engine.sv
// swap_engine: DEPTH x WIDTH register file that exchanges two entries using one of four swap styles.
// Modes 0-2 take 3 cycles from accept to done, mode 3 and a==b take 1; cmd_ready only while idle.
module swap_engine #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  localparam int IDXW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDXW-1:0]  wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [IDXW-1:0]  rd_addr,
  output logic [WIDTH-1:0] rd_data,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [IDXW-1:0]  cmd_a,
  input  logic [IDXW-1:0]  cmd_b,
  input  logic [1:0]       cmd_mode,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [15:0]      swap_count
);

  typedef enum logic [1:0] {ST_IDLE, ST_S1, ST_S2, ST_S3} state_t;

  localparam logic [1:0] MODE_TMP = 2'd0;
  localparam logic [1:0] MODE_ADD = 2'd1;
  localparam logic [1:0] MODE_XOR = 2'd2;
  localparam logic [1:0] MODE_PAR = 2'd3;

  // One extra bit so DEPTH itself is representable for the range compares.
  localparam logic [IDXW:0] LP_DEPTH = (IDXW+1)'(DEPTH);

  state_t            r_state;
  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [WIDTH-1:0]  r_tmp;
  logic [IDXW-1:0]   r_a;
  logic [IDXW-1:0]   r_b;
  logic [1:0]        r_mode;
  logic              r_done;
  logic              r_err;
  logic [15:0]       r_cnt;

  logic w_idle;
  logic w_wr_ok;
  logic w_cmd_in_range;
  logic w_rd_in_range;

  assign w_idle         = (r_state == ST_IDLE);
  assign w_wr_ok        = wr_en && w_idle && ({1'b0, wr_addr} < LP_DEPTH);
  assign w_cmd_in_range = ({1'b0, cmd_a} < LP_DEPTH) && ({1'b0, cmd_b} < LP_DEPTH);
  assign w_rd_in_range  = ({1'b0, rd_addr} < LP_DEPTH);

  assign rd_data    = w_rd_in_range ? r_mem[rd_addr] : '0;
  assign cmd_ready  = w_idle;
  assign busy       = !w_idle;
  assign done       = r_done;
  assign err        = r_err;
  assign swap_count = r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_tmp   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_mode  <= MODE_TMP;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // The swap steps only touch the file from S1 on, so a same-edge write is seen by the swap.
          if (w_wr_ok) r_mem[wr_addr] <= wr_data;
          if (cmd_valid) begin
            if (w_cmd_in_range) begin
              r_a     <= cmd_a;
              r_b     <= cmd_b;
              r_mode  <= cmd_mode;
              r_state <= ST_S1;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        ST_S1: begin
          if (r_a == r_b) begin
            // Self-swap writes nothing: the add and XOR styles would otherwise zero the entry.
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
            r_cnt   <= r_cnt + 16'd1;
          end else begin
            case (r_mode)
              MODE_TMP: r_tmp <= r_mem[r_a];
              MODE_ADD: r_mem[r_a] <= r_mem[r_a] + r_mem[r_b];
              MODE_XOR: r_mem[r_a] <= r_mem[r_a] ^ r_mem[r_b];
              default: begin
                r_mem[r_a] <= r_mem[r_b];
                r_mem[r_b] <= r_mem[r_a];
              end
            endcase
            if (r_mode == MODE_PAR) begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
              r_cnt   <= r_cnt + 16'd1;
            end else begin
              r_state <= ST_S2;
            end
          end
        end
        ST_S2: begin
          case (r_mode)
            MODE_TMP: r_mem[r_a] <= r_mem[r_b];
            MODE_ADD: r_mem[r_b] <= r_mem[r_a] - r_mem[r_b];
            MODE_XOR: r_mem[r_b] <= r_mem[r_a] ^ r_mem[r_b];
            default: ;
          endcase
          r_state <= ST_S3;
        end
        ST_S3: begin
          case (r_mode)
            MODE_TMP: r_mem[r_b] <= r_tmp;
            MODE_ADD: r_mem[r_a] <= r_mem[r_a] - r_mem[r_b];
            MODE_XOR: r_mem[r_a] <= r_mem[r_a] ^ r_mem[r_b];
            default: ;
          endcase
          r_state <= ST_IDLE;
          r_done  <= 1'b1;
          r_cnt   <= r_cnt + 16'd1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_swap_engine.sv
// Scoreboard bench: stimulus pushes expected swap results, a negedge monitor checks them on done/err.
module tb_swap_engine;

  logic clk;
  logic rst;

  logic        wr_en0, cmd_valid0, cmd_ready0, busy0, done0, err0;
  logic [2:0]  wr_addr0, rd_addr0, cmd_a0, cmd_b0;
  logic [31:0] wr_data0, rd_data0;
  logic [1:0]  cmd_mode0;
  logic [15:0] cnt0;

  logic        wr_en1, cmd_valid1, cmd_ready1, busy1, done1, err1;
  logic [2:0]  wr_addr1, rd_addr1, cmd_a1, cmd_b1;
  logic [7:0]  wr_data1, rd_data1;
  logic [1:0]  cmd_mode1;
  logic [15:0] cnt1;

  swap_engine #(.WIDTH(32), .DEPTH(8)) u_dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
    .rd_addr(rd_addr0), .rd_data(rd_data0), .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0),
    .cmd_a(cmd_a0), .cmd_b(cmd_b0), .cmd_mode(cmd_mode0), .busy(busy0), .done(done0),
    .err(err0), .swap_count(cnt0)
  );

  swap_engine #(.WIDTH(8), .DEPTH(6)) u_dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
    .rd_addr(rd_addr1), .rd_data(rd_data1), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
    .cmd_a(cmd_a1), .cmd_b(cmd_b1), .cmd_mode(cmd_mode1), .busy(busy1), .done(done1),
    .err(err1), .swap_count(cnt1)
  );

  typedef struct {
    int          a;
    int          b;
    bit          is_err;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [15:0] cnt;
    int          due;
  } exp_t;

  typedef struct {
    int          dut;
    int          idx;
    logic [31:0] exp;
  } peek_t;

  exp_t  q0[$];
  exp_t  q1[$];
  peek_t pq[$];
  int    ecnt[2];
  int    cyc = 0;
  int    n_chk = 0;
  int    n_pass = 0;

  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d: got 0x%0h, required 0x%0h (cycle %0d)", nm, k, act, exp, cyc);
  endtask

  task automatic rd_chk(int k, int idx, logic [31:0] e, string nm);
    if (k == 0) rd_addr0 = idx[2:0];
    else        rd_addr1 = idx[2:0];
    #1;
    chk(nm, k, (k == 0) ? rd_data0 : {24'd0, rd_data1}, e);
  endtask

  task automatic mon_event(int k, bit e_seen);
    exp_t it;
    if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
      n_chk++;
      $display("FAIL unexpected_event dut%0d: got done=%0d err=%0d, required nothing pending (cycle %0d)",
               k, (k == 0) ? done0 : done1, e_seen, cyc);
      return;
    end
    if (k == 0) it = q0.pop_front();
    else        it = q1.pop_front();
    chk("event_kind", k, 32'(e_seen), 32'(it.is_err));
    chk("swap_count", k, (k == 0) ? 32'(cnt0) : 32'(cnt1), 32'(it.cnt));
    chk("latency", k, 32'(cyc), 32'(it.due));
    rd_chk(k, it.a, it.ea, "entry_a");
    rd_chk(k, it.b, it.eb, "entry_b");
  endtask

  // Monitor: owns rd_addr, reacts to done/err and services read-back requests.
  initial begin
    peek_t pk;
    rd_addr0 = '0;
    rd_addr1 = '0;
    forever begin
      @(negedge clk);
      if (done0 || err0) mon_event(0, err0);
      if (done1 || err1) mon_event(1, err1);
      while (pq.size() > 0) begin
        pk = pq.pop_front();
        rd_chk(pk.dut, pk.idx, pk.exp, "readback");
      end
    end
  end

  task automatic peek(int k, int idx, logic [31:0] e);
    peek_t p;
    p.dut = k;
    p.idx = idx;
    p.exp = e;
    pq.push_back(p);
  endtask

  task automatic wr(int k, int a, logic [31:0] d);
    if (k == 0) begin wr_en0 = 1'b1; wr_addr0 = a[2:0]; wr_data0 = d; end
    else        begin wr_en1 = 1'b1; wr_addr1 = a[2:0]; wr_data1 = d[7:0]; end
    @(posedge clk); #1;
    wr_en0 = 1'b0;
    wr_en1 = 1'b0;
  endtask

  // Issues one command at the first cycle cmd_ready is seen; acc is the cycle index after acceptance.
  task automatic swap(int k, int a, int b, int mode, logic [31:0] ea, logic [31:0] eb,
                      int lat, bit is_err, bit push, output int acc);
    exp_t it;
    int t = 0;
    acc = 0;
    while (!((k == 0) ? cmd_ready0 : cmd_ready1)) begin
      @(posedge clk); #1;
      t++;
      if (t > 20) begin
        n_chk++;
        $display("FAIL ready_timeout dut%0d: got cmd_ready=0 for %0d cycles, required 1", k, t);
        return;
      end
    end
    if (k == 0) begin cmd_valid0 = 1'b1; cmd_a0 = a[2:0]; cmd_b0 = b[2:0]; cmd_mode0 = mode[1:0]; end
    else        begin cmd_valid1 = 1'b1; cmd_a1 = a[2:0]; cmd_b1 = b[2:0]; cmd_mode1 = mode[1:0]; end
    @(posedge clk); #1;
    acc = cyc;
    cmd_valid0 = 1'b0;
    cmd_valid1 = 1'b0;
    if (push) begin
      if (!is_err) ecnt[k]++;
      it.a = a; it.b = b; it.is_err = is_err; it.ea = ea; it.eb = eb;
      it.cnt = 16'(ecnt[k]); it.due = acc + lat;
      if (k == 0) q0.push_back(it);
      else        q1.push_back(it);
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((q0.size() + q1.size() + pq.size()) != 0 && t < 40) begin
      @(posedge clk); #1;
      t++;
    end
    n_chk++;
    if (t >= 40) $display("FAIL drain_timeout: got %0d items pending, required 0", q0.size() + q1.size() + pq.size());
    else n_pass++;
  endtask

  initial begin
    int acc1, acc2;
    rst = 1'b1;
    wr_en0 = 0; wr_addr0 = 0; wr_data0 = 0; cmd_valid0 = 0; cmd_a0 = 0; cmd_b0 = 0; cmd_mode0 = 0;
    wr_en1 = 0; wr_addr1 = 0; wr_data1 = 0; cmd_valid1 = 0; cmd_a1 = 0; cmd_b1 = 0; cmd_mode1 = 0;
    ecnt[0] = 0;
    ecnt[1] = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    chk("rst_busy", 0, 32'(busy0), 32'd0);
    chk("rst_ready", 0, 32'(cmd_ready0), 32'd1);
    chk("rst_done_err", 0, 32'({done0, err0}), 32'd0);
    chk("rst_count", 0, 32'(cnt0), 32'd0);
    chk("rst_ready", 1, 32'({cmd_ready1, busy1}), 32'd2);
    peek(0, 0, 0); peek(0, 7, 0); peek(1, 5, 0);
    wait_drain();

    // WIDTH=8: 200+100 overflows to 44 yet the exchange still comes out right.
    wr(1, 2, 200); wr(1, 3, 100);
    swap(1, 2, 3, 1, 100, 200, 3, 0, 1, acc1);
    wait_drain();
    // DEPTH=6: index 7 is rejected, entry 0 untouched, counter unchanged.
    wr(1, 0, 55);
    swap(1, 0, 7, 0, 55, 0, 0, 1, 1, acc1);
    wait_drain();
    wr(1, 6, 8'hAA);
    peek(1, 6, 0); peek(1, 0, 55);
    wait_drain();

    // Mode 0.
    wr(0, 0, 254); wr(0, 1, 566);
    swap(0, 0, 1, 0, 566, 254, 3, 0, 1, acc1);
    wait_drain();
    // Mode 1, with the partial sum visible after S1.
    wr(0, 2, 100); wr(0, 3, 426);
    swap(0, 2, 3, 1, 426, 100, 3, 0, 1, acc1);
    @(posedge clk); #1;
    peek(0, 2, 526);
    wait_drain();
    // Mode 1 with 32-bit wrap.
    wr(0, 4, 32'hFFFF_FF00); wr(0, 5, 32'h0000_0300);
    swap(0, 4, 5, 1, 32'h0000_0300, 32'hFFFF_FF00, 3, 0, 1, acc1);
    wait_drain();
    // Mode 2.
    wr(0, 4, 799); wr(0, 5, 826);
    swap(0, 4, 5, 2, 826, 799, 3, 0, 1, acc1);
    wait_drain();
    // Mode 3 and a back-to-back mode-3 accepted on the done cycle.
    wr(0, 6, 110); wr(0, 7, 221);
    swap(0, 6, 7, 3, 221, 110, 1, 0, 1, acc1);
    swap(0, 6, 7, 3, 110, 221, 1, 0, 1, acc2);
    chk("b2b_accept", 0, 32'(acc2), 32'(acc1 + 2));
    wait_drain();
    // Self-swap in the add and XOR styles must not zero the entry.
    wr(0, 2, 545);
    swap(0, 2, 2, 1, 545, 545, 1, 0, 1, acc1);
    wait_drain();
    swap(0, 2, 2, 2, 545, 545, 1, 0, 1, acc1);
    wait_drain();
    // Host write during S2 is dropped.
    swap(0, 0, 1, 0, 254, 566, 3, 0, 1, acc1);
    @(posedge clk); #1;
    wr(0, 0, 999);
    wait_drain();
    // Write and command on the same idle edge: swap uses the written value.
    wr_en0 = 1'b1; wr_addr0 = 3'd0; wr_data0 = 32'd7;
    swap(0, 0, 1, 2, 566, 7, 3, 0, 1, acc1);
    wr_en0 = 1'b0;
    wait_drain();

    // Reset in S2 of a mode-1 swap.
    wr(0, 2, 100); wr(0, 3, 426);
    swap(0, 2, 3, 1, 0, 0, 3, 0, 0, acc1);
    @(posedge clk); #1;
    peek(0, 2, 526);
    @(negedge clk); #5;
    rst = 1'b1;
    #1;
    chk("midrst_busy", 0, 32'(busy0), 32'd0);
    chk("midrst_ready", 0, 32'(cmd_ready0), 32'd1);
    chk("midrst_count", 0, 32'(cnt0), 32'd0);
    chk("midrst_count", 1, 32'(cnt1), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    ecnt[0] = 0;
    ecnt[1] = 0;
    for (int i = 0; i < 8; i++) peek(0, i, 0);
    for (int i = 0; i < 6; i++) peek(1, i, 0);
    wait_drain();

    // Normal operation resumes after reset.
    wr(0, 0, 1); wr(0, 1, 2);
    swap(0, 0, 1, 3, 2, 1, 1, 0, 1, acc1);
    wait_drain();
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
